// File: rtl/mem_access.sv
// mem_access: memory-access stage of the in-order RISC-V pipeline.
//
// Issues one TileLink-style Get/PutFullData per load/store, using the ALU
// result as the byte address. The pipeline stalls while the transaction is
// outstanding. Load data is aligned, sign/zero-extended and held until the
// DONE state exits. A combinational forwarding value (ma_data) and the
// registered MA/WB outputs (pc_out, rd_out, data_out) are produced here.
//
// Ports:
//   clk, rst_n       clock; rst_n is a synchronous ACTIVE-HIGH reset
//   clear            flush: suppress this instruction's writeback
//   op_load/op_store/op_size/op_unsigned  operation controls
//   pc, rd, result, data2                 instruction inputs (held while stall)
//   ma_data          combinational forwarding value
//   pc_out, rd_out, data_out              registered writeback outputs
//   stall, request   pipeline hold / bus transaction in flight
//   a_*              bus A channel (request), a_ready input
//   d_valid, d_data  bus D channel (response), d_ready output
module mem_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        op_load,
    input  logic        op_store,
    input  logic [1:0]  op_size,
    input  logic        op_unsigned,
    input  logic [63:0] pc,
    input  logic [4:0]  rd,
    input  logic [63:0] result,
    input  logic [63:0] data2,
    output logic [63:0] ma_data,
    output logic [63:0] pc_out,
    output logic [4:0]  rd_out,
    output logic [63:0] data_out,
    output logic        stall,
    output logic        request,
    output logic        a_valid,
    output logic [2:0]  a_opcode,
    output logic [63:0] a_address,
    output logic [1:0]  a_size,
    output logic [7:0]  a_mask,
    output logic [63:0] a_data,
    input  logic        a_ready,
    input  logic        d_valid,
    input  logic [63:0] d_data,
    output logic        d_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [2:0] OPC_GET = 3'd4;
    localparam logic [2:0] OPC_PUT = 3'd0;

    // Byte-lane mask for an access of the given size at lane offset 0.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            2'd3:    m = 8'hFF;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    // Truncate an already right-aligned load value to its size and extend it.
    function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                                input logic [1:0]  size,
                                                input logic        uns);
        logic [63:0] v;
        case (size)
            2'd0:    v = uns ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            2'd1:    v = uns ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            2'd2:    v = uns ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            2'd3:    v = raw;
            default: v = 64'd0;
        endcase
        return v;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic        mem_op_s;
    logic [5:0]  lane_shift_s;
    logic [63:0] load_ext_s;
    logic [63:0] load_data_r;
    logic        discard_r;
    logic [2:0]  a_opcode_r;
    logic [63:0] a_address_r;
    logic [1:0]  a_size_r;
    logic [7:0]  a_mask_r;
    logic [63:0] a_data_r;

    assign mem_op_s     = (op_load | op_store) & ~clear;
    assign lane_shift_s = {result[2:0], 3'b000};
    assign load_ext_s   = extend_load(d_data >> lane_shift_s, op_size, op_unsigned);

    // State register.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and control decode.
    always_comb begin
        state_next_s = state_r;
        a_valid      = 1'b0;
        d_ready      = 1'b0;
        request      = 1'b0;
        stall        = 1'b0;
        case (state_r)
            IDLE: begin
                // Only a live (unflushed) memory op holds the pipeline here.
                stall = mem_op_s;
                if (mem_op_s) begin
                    state_next_s = REQ;
                end else begin
                    state_next_s = IDLE;
                end
            end
            REQ: begin
                a_valid = 1'b1;
                request = 1'b1;
                stall   = 1'b1;
                if (a_ready) begin
                    state_next_s = RESP;
                end else begin
                    state_next_s = REQ;
                end
            end
            RESP: begin
                d_ready = 1'b1;
                request = 1'b1;
                stall   = 1'b1;
                if (d_valid) begin
                    state_next_s = DONE;
                end else begin
                    state_next_s = RESP;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // A-channel fields latched on issue so they cannot move while a_valid waits.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_opcode_r  <= 3'd0;
            a_address_r <= 64'd0;
            a_size_r    <= 2'd0;
            a_mask_r    <= 8'd0;
            a_data_r    <= 64'd0;
        end else if (state_r == IDLE && mem_op_s) begin
            a_opcode_r  <= op_load ? OPC_GET : OPC_PUT;
            a_address_r <= result;
            a_size_r    <= op_size;
            a_mask_r    <= size_mask(op_size) << result[2:0];
            a_data_r    <= data2 << lane_shift_s;
        end else begin
            a_opcode_r  <= a_opcode_r;
            a_address_r <= a_address_r;
            a_size_r    <= a_size_r;
            a_mask_r    <= a_mask_r;
            a_data_r    <= a_data_r;
        end
    end

    assign a_opcode  = a_opcode_r;
    assign a_address = a_address_r;
    assign a_size    = a_size_r;
    assign a_mask    = a_mask_r;
    assign a_data    = a_data_r;

    // Load data capture on the D-channel handshake; held through DONE.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            load_data_r <= 64'd0;
        end else if (state_r == RESP && d_valid && op_load) begin
            load_data_r <= load_ext_s;
        end else begin
            load_data_r <= load_data_r;
        end
    end

    // Remembers a flush seen mid-transaction: the bus still completes, but the
    // writeback in DONE becomes a bubble even if clear has since dropped.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            discard_r <= 1'b0;
        end else if (state_r == DONE || state_r == IDLE) begin
            discard_r <= 1'b0;
        end else if (clear) begin
            discard_r <= 1'b1;
        end else begin
            discard_r <= discard_r;
        end
    end

    assign ma_data = op_load ? load_data_r : result;

    // MA/WB output registers.
    always_ff @(posedge clk) begin
        if (rst_n || clear) begin
            pc_out   <= 64'd0;
            rd_out   <= 5'd0;
            data_out <= 64'd0;
        end else if (stall || discard_r) begin
            pc_out   <= 64'd0;
            rd_out   <= 5'd0;
            data_out <= 64'd0;
        end else begin
            pc_out   <= pc;
            rd_out   <= rd;
            data_out <= ma_data;
        end
    end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        op_load;
    logic        op_store;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] result;
    logic [63:0] data2;
    logic [63:0] ma_data;
    logic [63:0] pc_out;
    logic [4:0]  rd_out;
    logic [63:0] data_out;
    logic        stall;
    logic        request;
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [63:0] a_address;
    logic [1:0]  a_size;
    logic [7:0]  a_mask;
    logic [63:0] a_data;
    logic        a_ready;
    logic        d_valid;
    logic [63:0] d_data;
    logic        d_ready;

    int checks;
    int errors;

    mem_access dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .op_load(op_load), .op_store(op_store), .op_size(op_size),
        .op_unsigned(op_unsigned), .pc(pc), .rd(rd), .result(result),
        .data2(data2), .ma_data(ma_data), .pc_out(pc_out), .rd_out(rd_out),
        .data_out(data_out), .stall(stall), .request(request),
        .a_valid(a_valid), .a_opcode(a_opcode), .a_address(a_address),
        .a_size(a_size), .a_mask(a_mask), .a_data(a_data), .a_ready(a_ready),
        .d_valid(d_valid), .d_data(d_data), .d_ready(d_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1; clear = 1'b0;
        op_load = 1'b0; op_store = 1'b0; op_size = 2'd0; op_unsigned = 1'b0;
        pc = 64'd0; rd = 5'd0; result = 64'd0; data2 = 64'd0;
        a_ready = 1'b1; d_valid = 1'b1; d_data = 64'd0;
        step(); step();
        check("rst_a_valid", {63'd0, a_valid}, 64'd0);
        check("rst_d_ready", {63'd0, d_ready}, 64'd0);
        check("rst_request", {63'd0, request}, 64'd0);
        check("rst_stall",   {63'd0, stall},   64'd0);
        check("rst_rd_out",  {59'd0, rd_out},  64'd0);
        check("rst_data_out", data_out, 64'd0);
        check("rst_pc_out",   pc_out,   64'd0);
        rst_n = 1'b0;

        // ALU op: no stall, registered one cycle later.
        pc = 64'h400; rd = 5'd5; result = 64'h1234;
        #1 check("alu_stall", {63'd0, stall}, 64'd0);
        check("alu_ma_data", ma_data, 64'h1234);
        step();
        check("alu_rd_out",   {59'd0, rd_out}, 64'd5);
        check("alu_data_out", data_out, 64'h1234);
        check("alu_pc_out",   pc_out,   64'h400);

        // Store double at 0x100, zero-wait bus.
        op_store = 1'b1; op_size = 2'd3; result = 64'h100; rd = 5'd0; pc = 64'h404;
        data2 = 64'hDEADBEEF_CAFEF00D;
        #1 check("st_idle_stall", {63'd0, stall}, 64'd1);
        step();
        check("st_req_valid",  {63'd0, a_valid}, 64'd1);
        check("st_req_opcode", {61'd0, a_opcode}, 64'd0);
        check("st_req_mask",   {56'd0, a_mask}, 64'hFF);
        check("st_req_addr",   a_address, 64'h100);
        check("st_req_data",   a_data, 64'hDEADBEEF_CAFEF00D);
        check("st_req_stall",  {63'd0, stall}, 64'd1);
        check("st_rd_bubble",  {59'd0, rd_out}, 64'd0);
        step();
        check("st_resp_dready", {63'd0, d_ready}, 64'd1);
        check("st_resp_stall",  {63'd0, stall}, 64'd1);
        step();
        check("st_done_stall",  {63'd0, stall}, 64'd0);
        check("st_done_avalid", {63'd0, a_valid}, 64'd0);
        step();
        check("st_wb_rd", {59'd0, rd_out}, 64'd0);

        // Load double, same address.
        op_store = 1'b0; op_load = 1'b1; op_size = 2'd3; result = 64'h100;
        rd = 5'd7; pc = 64'h408; d_data = 64'hDEADBEEF_CAFEF00D;
        step();
        check("ld_req_opcode", {61'd0, a_opcode}, 64'd4);
        step(); step();
        check("ld_done_ma_data", ma_data, 64'hDEADBEEF_CAFEF00D);
        check("ld_done_stall", {63'd0, stall}, 64'd0);
        step();
        check("ld_wb_data", data_out, 64'hDEADBEEF_CAFEF00D);
        check("ld_wb_rd",   {59'd0, rd_out}, 64'd7);
        check("ld_wb_pc",   pc_out, 64'h408);

        // Load byte signed at 0x103.
        op_size = 2'd0; result = 64'h103; rd = 5'd8; d_data = 64'h00000000_DE000000;
        step();
        check("lb_req_mask", {56'd0, a_mask}, 64'h08);
        step(); step(); step();
        check("lb_signed", data_out, 64'hFFFF_FFFF_FFFF_FFDE);

        // Load byte unsigned at 0x103.
        op_unsigned = 1'b1; rd = 5'd9;
        step(); step(); step(); step();
        check("lbu_unsigned", data_out, 64'h0000_0000_0000_00DE);
        op_unsigned = 1'b0;

        // Store half 0xABCD at 0x106.
        op_load = 1'b0; op_store = 1'b1; op_size = 2'd1; result = 64'h106;
        data2 = 64'h0000_0000_0000_ABCD; rd = 5'd0;
        step();
        check("sh_mask", {56'd0, a_mask}, 64'hC0);
        check("sh_data", a_data, 64'hABCD_0000_0000_0000);
        step(); step(); step();

        // Load word signed at 0x104 with bus wait states.
        op_store = 1'b0; op_load = 1'b1; op_size = 2'd2; result = 64'h104; rd = 5'd10;
        d_data = 64'h80000000_00000000; a_ready = 1'b0; d_valid = 1'b0;
        step(); step();
        check("lw_wait_avalid", {63'd0, a_valid}, 64'd1);
        check("lw_wait_addr", a_address, 64'h104);
        a_ready = 1'b1;
        step(); step();
        check("lw_wait_dready", {63'd0, d_ready}, 64'd1);
        check("lw_wait_stall",  {63'd0, stall}, 64'd1);
        d_valid = 1'b1;
        step(); step();
        check("lw_wait_data", data_out, 64'hFFFF_FFFF_8000_0000);
        check("lw_wait_rd",   {59'd0, rd_out}, 64'd10);

        // clear during RESP: handshake completes, writeback discarded.
        result = 64'h108; rd = 5'd11; d_valid = 1'b0; d_data = 64'h1111_2222_3333_4444;
        step(); step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("clr_resp_request", {63'd0, request}, 64'd1);
        d_valid = 1'b1;
        step();
        check("clr_done_stall", {63'd0, stall}, 64'd0);
        step();
        check("clr_wb_rd",   {59'd0, rd_out}, 64'd0);
        check("clr_wb_data", data_out, 64'd0);

        // clear in IDLE: no transaction issued.
        clear = 1'b1;
        #1 check("clr_idle_stall", {63'd0, stall}, 64'd0);
        step();
        check("clr_idle_avalid", {63'd0, a_valid}, 64'd0);
        check("clr_idle_rd",     {59'd0, rd_out}, 64'd0);
        clear = 1'b0; op_load = 1'b0;
        step();

        // Reset asserted in REQ.
        op_load = 1'b1; op_size = 2'd3; result = 64'h100; rd = 5'd12; a_ready = 1'b0;
        step();
        check("rstreq_avalid", {63'd0, a_valid}, 64'd1);
        rst_n = 1'b1; op_load = 1'b0;
        step();
        check("rstreq_avalid_after", {63'd0, a_valid}, 64'd0);
        check("rstreq_request",      {63'd0, request}, 64'd0);
        check("rstreq_rd",           {59'd0, rd_out}, 64'd0);
        rst_n = 1'b0; a_ready = 1'b1;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
